// File: rtl/eth_mac_tx_framer_if.sv
// Raw Ethernet frame byte stream from the ARP/UDP transmit mux into the framer.
interface eth_mac_tx_framer_if;
    logic       mac_tx_valid;
    logic [7:0] mac_tx_data;

    modport master (output mac_tx_valid, output mac_tx_data);
    modport slave  (input  mac_tx_valid, input  mac_tx_data);
endinterface

// File: rtl/eth_mac_tx_framer.sv
// GMII transmit framer: preamble/SFD, zero padding to MIN_FRAME, CRC-32 FCS and
// inter-packet gap around a raw frame byte stream.
module eth_mac_tx_framer #(
    parameter logic [15:0] MIN_FRAME  = 16'd60,
    parameter logic [7:0]  IPG_CYCLES = 8'd12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    eth_mac_tx_framer_if.slave        mac,
    output logic                      gmii_tx_en,
    output logic [7:0]                gmii_txd,
    output logic                      tx_busy,
    output logic                      frame_done,
    output logic                      frame_drop
);
    localparam int unsigned DL_DEPTH = 8;
    localparam int unsigned DL_HEAD  = DL_DEPTH - 1;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [15:0] PRE_LAST = 16'd6;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IPG
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [7:0] data;
    } dl_entry_t;

    state_t      state_q, state_d;
    dl_entry_t   dl_q [DL_DEPTH];
    dl_entry_t   dl_d [DL_DEPTH];
    logic [31:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  ipg_q, ipg_d;
    logic [1:0]  fcs_idx_q, fcs_idx_d;
    logic        valid_prev_q, valid_prev_d;
    logic        accept_q, accept_d;
    logic        ignore_q, ignore_d;
    logic        done_pend_q, done_pend_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        drop_q, drop_d;
    logic        start_c;
    logic        rise_c;
    logic        pad_step_c;

    // Reflected CRC-32 update over one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h000000, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        logic [31:0] f;
        f = ~crc;
        return f[{idx, 3'b000} +: 8];
    endfunction

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        cnt_d        = cnt_q;
        ipg_d        = ipg_q;
        fcs_idx_d    = fcs_idx_q;
        valid_prev_d = mac.mac_tx_valid;
        done_pend_d  = 1'b0;
        tx_en_d      = 1'b0;
        txd_d        = 8'h00;
        busy_d       = (state_q != S_IDLE);
        done_d       = done_pend_q;
        drop_d       = 1'b0;
        pad_step_c   = 1'b0;

        rise_c   = mac.mac_tx_valid && !valid_prev_q;
        start_c  = (state_q == S_IDLE) && mac.mac_tx_valid && !ignore_q;
        accept_d = start_c || (accept_q && mac.mac_tx_valid);
        ignore_d = ignore_q && mac.mac_tx_valid;

        // A frame arriving while busy is swallowed whole until its valid falls.
        if (rise_c && (state_q != S_IDLE)) begin
            drop_d   = 1'b1;
            ignore_d = 1'b1;
        end

        dl_d[0].vld  = mac.mac_tx_valid && (start_c || accept_q);
        dl_d[0].data = mac.mac_tx_data;
        for (int i = 1; i < DL_DEPTH; i++) begin
            dl_d[i] = dl_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d   = S_PREAMBLE;
                    tx_en_d   = 1'b1;
                    txd_d     = 8'h55;
                    crc_d     = CRC_INIT;
                    cnt_d     = 16'd0;
                    fcs_idx_d = 2'd0;
                end
            end
            S_PREAMBLE: begin
                tx_en_d = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                if (cnt_q == PRE_LAST) begin
                    txd_d   = 8'hD5;
                    cnt_d   = 16'd0;
                    state_d = S_DATA;
                end else begin
                    txd_d = 8'h55;
                end
            end
            S_DATA: begin
                tx_en_d = 1'b1;
                if (dl_q[DL_HEAD].vld) begin
                    txd_d = dl_q[DL_HEAD].data;
                    crc_d = crc_byte(crc_q, dl_q[DL_HEAD].data);
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
                end else begin
                    pad_step_c = 1'b1;
                end
            end
            S_PAD: begin
                tx_en_d    = 1'b1;
                pad_step_c = 1'b1;
            end
            S_FCS: begin
                tx_en_d   = 1'b1;
                txd_d     = fcs_byte(crc_q, fcs_idx_q);
                fcs_idx_d = fcs_idx_q + 2'd1;
                if (fcs_idx_q == 2'd3) begin
                    ipg_d = 8'd0;
                    if (IPG_CYCLES == 8'd0) begin
                        state_d     = S_IDLE;
                        done_pend_d = 1'b1;
                    end else begin
                        state_d = S_IPG;
                    end
                end
            end
            S_IPG: begin
                ipg_d = ipg_q + 8'd1;
                if (ipg_q == IPG_CYCLES - 8'd1) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // End of data or inside padding: emit a pad byte, or the first FCS byte with no bubble.
        if (pad_step_c) begin
            if (cnt_q < MIN_FRAME) begin
                txd_d     = 8'h00;
                crc_d     = crc_byte(crc_q, 8'h00);
                cnt_d     = cnt_q + 16'd1;
                fcs_idx_d = 2'd0;
                state_d   = ((cnt_q + 16'd1) >= MIN_FRAME) ? S_FCS : S_PAD;
            end else begin
                txd_d     = fcs_byte(crc_q, 2'd0);
                fcs_idx_d = 2'd1;
                state_d   = S_FCS;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dl_q         <= '{default: '0};
            crc_q        <= CRC_INIT;
            cnt_q        <= 16'd0;
            ipg_q        <= 8'd0;
            fcs_idx_q    <= 2'd0;
            valid_prev_q <= 1'b0;
            accept_q     <= 1'b0;
            ignore_q     <= 1'b0;
            done_pend_q  <= 1'b0;
            tx_en_q      <= 1'b0;
            txd_q        <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dl_q         <= dl_d;
            crc_q        <= crc_d;
            cnt_q        <= cnt_d;
            ipg_q        <= ipg_d;
            fcs_idx_q    <= fcs_idx_d;
            valid_prev_q <= valid_prev_d;
            accept_q     <= accept_d;
            ignore_q     <= ignore_d;
            done_pend_q  <= done_pend_d;
            tx_en_q      <= tx_en_d;
            txd_q        <= txd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
        end
    end

    assign gmii_tx_en = tx_en_q;
    assign gmii_txd   = txd_q;
    assign tx_busy    = busy_q;
    assign frame_done = done_q;
    assign frame_drop = drop_q;
endmodule

// File: tb/tb_eth_mac_tx_framer.sv
// Directed bench for eth_mac_tx_framer: one instance without padding, one with defaults.
module tb_eth_mac_tx_framer;
    typedef logic [7:0] bq_t [$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_mac_tx_framer_if a_if ();
    eth_mac_tx_framer_if b_if ();

    logic       a_en, a_busy, a_done, a_drop;
    logic [7:0] a_txd;
    logic       b_en, b_busy, b_done, b_drop;
    logic [7:0] b_txd;

    eth_mac_tx_framer #(.MIN_FRAME(16'd0), .IPG_CYCLES(8'd12)) dut_a (
        .clk(clk), .rst_n(rst_n), .mac(a_if.slave),
        .gmii_tx_en(a_en), .gmii_txd(a_txd), .tx_busy(a_busy),
        .frame_done(a_done), .frame_drop(a_drop)
    );

    eth_mac_tx_framer dut_b (
        .clk(clk), .rst_n(rst_n), .mac(b_if.slave),
        .gmii_tx_en(b_en), .gmii_txd(b_txd), .tx_busy(b_busy),
        .frame_done(b_done), .frame_drop(b_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_k  = 0;
    int en_cnt [2], en_rise [2], done_cnt [2], drop_cnt [2];
    int first_en [2], last_en [2], done_cyc [2], busy_fall [2], idle_bad [2];
    logic prev_en [2], prev_busy [2];
    bq_t cap_a, cap_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input bq_t d);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    function automatic bq_t build_exp(input bq_t d, input int min_len);
        bq_t         e;
        bq_t         body;
        logic [31:0] f;
        body = d;
        for (int i = 0; i < 7; i++) e.push_back(8'h55);
        e.push_back(8'hD5);
        while (body.size() < min_len) body.push_back(8'h00);
        f = crc32(body);
        foreach (body[i]) e.push_back(body[i]);
        for (int b = 0; b < 4; b++) e.push_back(f[8*b +: 8]);
        return e;
    endfunction

    task automatic mon_step(input int s, input logic en, input logic [7:0] txd,
                            input logic busy, input logic done, input logic drop);
        if (en) begin
            en_cnt[s]++;
            if (!prev_en[s]) begin
                en_rise[s]++;
                if (first_en[s] < 0) first_en[s] = cyc;
            end
            last_en[s] = cyc;
            if (s == 0) cap_a.push_back(txd);
            else        cap_b.push_back(txd);
        end else if (txd !== 8'h00) begin
            idle_bad[s]++;
        end
        if (done) begin
            done_cnt[s]++;
            done_cyc[s] = cyc;
        end
        if (drop) drop_cnt[s]++;
        if (prev_busy[s] && !busy) busy_fall[s] = cyc;
        prev_en[s]   = en;
        prev_busy[s] = busy;
    endtask

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        mon_step(0, a_en, a_txd, a_busy, a_done, a_drop);
        mon_step(1, b_en, b_txd, b_busy, b_done, b_drop);
    end

    task automatic clear_mon();
        for (int s = 0; s < 2; s++) begin
            en_cnt[s] = 0; en_rise[s] = 0; done_cnt[s] = 0; drop_cnt[s] = 0;
            first_en[s] = -1; last_en[s] = -1; done_cyc[s] = -1; busy_fall[s] = -1;
            idle_bad[s] = 0; prev_en[s] = 1'b0; prev_busy[s] = 1'b0;
        end
        cap_a.delete();
        cap_b.delete();
    endtask

    task automatic send(input int s, input bq_t d);
        foreach (d[i]) begin
            @(negedge clk);
            if (i == 0) start_k = cyc + 1;
            if (s == 0) begin a_if.mac_tx_valid = 1'b1; a_if.mac_tx_data = d[i]; end
            else        begin b_if.mac_tx_valid = 1'b1; b_if.mac_tx_data = d[i]; end
        end
        @(negedge clk);
        if (s == 0) begin a_if.mac_tx_valid = 1'b0; a_if.mac_tx_data = 8'h00; end
        else        begin b_if.mac_tx_valid = 1'b0; b_if.mac_tx_data = 8'h00; end
    endtask

    task automatic wait_done(input int s, input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt[s] == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt[s] == 0) check(tag, 32'(done_cnt[s]), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_frame(input int s, input bq_t e, input string tag);
        bq_t c;
        int  n;
        c = (s == 0) ? cap_a : cap_b;
        check({tag, "_len"}, 32'(c.size()), 32'(e.size()));
        n = (c.size() < e.size()) ? c.size() : e.size();
        for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), 32'(c[i]), 32'(e[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t d, d2, e;
        int  g;
        a_if.mac_tx_valid = 1'b0; a_if.mac_tx_data = 8'h00;
        b_if.mac_tx_valid = 1'b0; b_if.mac_tx_data = 8'h00;
        clear_mon();
        repeat (3) @(negedge clk);
        check("rst_a_outs", 32'({a_en, a_txd, a_busy, a_done, a_drop}), 32'd0);
        check("rst_b_outs", 32'({b_en, b_txd, b_busy, b_done, b_drop}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // "123456789" without padding: known check value CBF43926
        clear_mon();
        d.delete();
        for (int i = 0; i < 9; i++) d.push_back(8'h31 + 8'(i));
        e.delete();
        for (int i = 0; i < 7; i++) e.push_back(8'h55);
        e.push_back(8'hD5);
        foreach (d[i]) e.push_back(d[i]);
        e.push_back(8'h26); e.push_back(8'h39); e.push_back(8'hF4); e.push_back(8'hCB);
        send(0, d);
        wait_done(0, 200, "t1_timeout");
        compare_frame(0, e, "t1");
        check("t1_en_cycles", 32'(en_cnt[0]), 32'd21);
        check("t1_en_rises", 32'(en_rise[0]), 32'd1);
        check("t1_start_lat", 32'(first_en[0]), 32'(start_k));
        check("t1_done_cnt", 32'(done_cnt[0]), 32'd1);
        check("t1_done_pos", 32'(done_cyc[0]), 32'(last_en[0] + 12));
        check("t1_busy_fall", 32'(busy_fall[0]), 32'(done_cyc[0] + 1));
        check("t1_ipg_txd", 32'(idle_bad[0]), 32'd0);

        // 42-byte ARP frame, padded to 60
        clear_mon();
        d.delete();
        for (int i = 0; i < 42; i++) d.push_back((i < 6) ? 8'hFF : 8'(i * 13 + 1));
        send(1, d);
        wait_done(1, 300, "t2_timeout");
        compare_frame(1, build_exp(d, 60), "t2");
        check("t2_en_cycles", 32'(en_cnt[1]), 32'd72);
        check("t2_done_pos", 32'(done_cyc[1]), 32'(last_en[1] + 12));
        check("t2_drop_cnt", 32'(drop_cnt[1]), 32'd0);
        check("t2_ipg_txd", 32'(idle_bad[1]), 32'd0);

        // 1000-byte frame: start latency, first data at k+8, no bubbles
        clear_mon();
        d.delete();
        for (int i = 0; i < 1000; i++) d.push_back(8'(i * 37 + i / 5));
        send(1, d);
        wait_done(1, 1200, "t3_timeout");
        check("t3_start_lat", 32'(first_en[1]), 32'(start_k));
        check("t3_first_data", 32'(cap_b.size() > 8 ? cap_b[8] : 8'hXX), 32'(d[0]));
        check("t3_en_rises", 32'(en_rise[1]), 32'd1);
        check("t3_en_cycles", 32'(en_cnt[1]), 32'd1012);
        compare_frame(1, build_exp(d, 60), "t3");

        // Second frame starts during drain and outlasts the first: dropped whole
        clear_mon();
        d.delete();
        for (int i = 0; i < 20; i++) d.push_back(8'hC0 + 8'(i));
        d2.delete();
        for (int i = 0; i < 150; i++) d2.push_back(8'hA0 + 8'(i));
        send(1, d);
        repeat (2) @(negedge clk);
        send(1, d2);
        wait_done(1, 300, "t4_timeout");
        repeat (40) @(negedge clk);
        check("t4_drop_cnt", 32'(drop_cnt[1]), 32'd1);
        check("t4_done_cnt", 32'(done_cnt[1]), 32'd1);
        check("t4_en_rises", 32'(en_rise[1]), 32'd1);
        check("t4_en_cycles", 32'(en_cnt[1]), 32'd72);
        check("t4_busy_end", 32'(b_busy), 32'd0);
        compare_frame(1, build_exp(d, 60), "t4");

        // Async reset during data byte 20, then a fresh frame
        clear_mon();
        d.delete();
        for (int i = 0; i < 40; i++) d.push_back(8'h11 * 8'(i % 15) + 8'h03);
        g = 0;
        fork
            send(1, d);
            begin
                while (cap_b.size() < 29 && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                check("t5_en_before", 32'(b_en), 32'd1);
                #1 rst_n = 1'b0;
                #1 check("t5_rst_async", 32'({b_en, b_txd, b_busy, b_done, b_drop}), 32'd0);
            end
        join
        repeat (2) @(negedge clk);
        check("t5_no_fcs", 32'(en_cnt[1]), 32'd29);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
        d.delete();
        for (int i = 0; i < 30; i++) d.push_back(8'h70 + 8'(i * 3));
        send(1, d);
        wait_done(1, 300, "t5_timeout");
        check("t5_en_cycles", 32'(en_cnt[1]), 32'd72);
        compare_frame(1, build_exp(d, 60), "t5");

        // Exactly 60 bytes: FCS directly after the last data byte
        clear_mon();
        d.delete();
        for (int i = 0; i < 60; i++) d.push_back(8'h5A ^ 8'(i));
        send(1, d);
        wait_done(1, 300, "t6_timeout");
        check("t6_en_cycles", 32'(en_cnt[1]), 32'd72);
        check("t6_done_cnt", 32'(done_cnt[1]), 32'd1);
        compare_frame(1, build_exp(d, 60), "t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/eth_mac_tx_framer.md
Name: eth_mac_tx_framer

Overview:
Downstream stage of the ARP/UDP transmit mux. Consumes the raw Ethernet frame byte stream (destination MAC through end of payload) on mac_tx_valid/mac_tx_data and produces a GMII-ready frame. The framer prepends the preamble and SFD, zero-pads short frames, appends the CRC-32 FCS, and enforces the inter-packet gap. Its outputs drive the RGMII/GMII transmit adapter directly.

Parameters:
MIN_FRAME, 16'd60, minimum byte count before FCS; shorter frames are zero-padded; 0 disables padding.
IPG_CYCLES, 8'd12, idle cycles forced after the last FCS byte.

Ports:
clk  input  1  system clock, one byte per cycle
rst_n  input  1  asynchronous active-low reset
mac_tx_valid  input  1  frame byte valid; contiguous high for the whole frame; low ends the frame
mac_tx_data  input  8  frame byte
gmii_tx_en  output  1  transmit enable to PHY adapter
gmii_txd  output  8  transmit byte to PHY adapter
tx_busy  output  1  high whenever state is not IDLE
frame_done  output  1  one-cycle pulse on the cycle of the last IPG cycle
frame_drop  output  1  one-cycle pulse when an input frame is discarded

Behaviour:
- Reset (async, rst_n low): state IDLE; gmii_tx_en=0, gmii_txd=8'h00, tx_busy=0, frame_done=0, frame_drop=0; CRC register=32'hFFFFFFFF; byte and IPG counters=0; delay line cleared with valid bits=0. Reset mid-frame aborts immediately: no FCS is emitted and tx_en drops.
- All outputs are registered.
- Delay line: 8-stage shift register of {valid,data}, shifting every cycle. An input byte sampled at edge k exits the line at edge k+8.
- States: IDLE, PREAMBLE, DATA, PAD, FCS, IPG.
- IDLE: when mac_tx_valid is sampled high at edge k, go to PREAMBLE. At edge k, gmii_tx_en=1 and gmii_txd=8'h55. Reset the CRC and the byte counter.
- PREAMBLE: outputs 8'h55 for a total of 7 cycles, then 8'hD5 on the 8th cycle (edge k+7). Then go to DATA.
- DATA: output the delay-line head byte; the input byte from edge k is output at edge k+8. Update the CRC and byte counter on each output byte. When the delay-line head valid bit is 0, the next state is PAD if byte count < MIN_FRAME, else FCS. In either case the transition cycle already outputs the first PAD or FCS byte, so there is no bubble.
- PAD: output 8'h00, included in the CRC, until byte count = MIN_FRAME, then go to FCS.
- FCS: 4 cycles, outputting ~crc bytes in order [7:0],[15:8],[23:16],[31:24].
- CRC: IEEE 802.3 reflected CRC-32, polynomial 32'hEDB88320, LSB-first per byte, init 32'hFFFFFFFF. Covers DATA and PAD bytes only.
- IPG: gmii_tx_en=0 and gmii_txd=0 for IPG_CYCLES cycles. frame_done pulses on the final IPG cycle, then go to IDLE. With IPG_CYCLES=0, go FCS to IDLE directly and pulse frame_done on the cycle after the last FCS byte.
- Byte counter: 16 bits, saturates at 16'hFFFF; no maximum frame length is enforced.
- Drop rule: if mac_tx_valid rises (low→high) while state is not IDLE (draining DATA, PAD, FCS or IPG):
  - frame_drop pulses the following cycle;
  - the entire new frame is ignored until mac_tx_valid goes low; its bytes never enter the delay line;
  - the current frame completes unaffected.
- If valid is still high when IDLE is re-entered and the frame was already dropped, it is not started. A frame starts only on a sampled rising edge, or on valid high at reset release in IDLE.
- Upstream contract: start the next frame only while tx_busy=0.

Test Plan:
1. MIN_FRAME=0, IPG=12; send the 9 bytes of ASCII "123456789" → gmii_txd = 55×7, D5, 31..39, then 26 39 F4 CB. tx_en is high for exactly 21 cycles, then low for 12 cycles; frame_done pulses once, and tx_busy falls the cycle after.
2. Defaults; send a 42-byte ARP frame → 42 data bytes followed by 18 bytes of 00, then a 4-byte FCS matching the reference CRC model over 60 bytes. tx_en is high for 72 cycles.
3. Latency check: valid rises at edge k → tx_en=1 at edge k; first data byte appears at edge k+8; back-to-back 1000-byte frame shows no bubbles.
4. Start a second frame 3 cycles after the first ends (during drain) → frame_drop pulses once; first frame's FCS is correct; the second frame produces no output.
5. Assert rst_n low during DATA byte 20 → outputs are 0 asynchronously. A frame sent after release is framed correctly with a fresh CRC.
6. Exact 60-byte frame → no PAD cycles; FCS follows the 60th byte immediately.
